// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: one aligned access at a time on a valid/ready data bus,
// with byte-lane steering, write strobes, misalignment detection and load extension.
module rv32i_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic        resp_we,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [0:0] {IDLE, MEM} state_t;

  state_t      state;
  logic        accept_p0;
  logic        legal_p0;
  logic        store_p1;
  logic [2:0]  funct3_p1;
  logic [1:0]  addr_lo_p1;
  logic [4:0]  rd_p1;

  function automatic logic is_legal(input logic st, input logic [2:0] f3,
                                    input logic [1:0] lo);
    logic ok_op;
    logic ok_align;
    if (st)
      ok_op = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else
      ok_op = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
              (f3 == 3'd4) || (f3 == 3'd5);
    case (f3[1:0])
      2'd1:    ok_align = ~lo[0];
      2'd2:    ok_align = (lo == 2'b00);
      default: ok_align = 1'b1;
    endcase
    return ok_op && ok_align;
  endfunction

  function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] s;
    case (size)
      2'd0:    s = 4'b0001 << lo;
      2'd1:    s = 4'b0011 << lo;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Replicating the datum across lanes lets the strobes alone pick the bytes.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      2'd0:    d = {4{wd[7:0]}};
      2'd1:    d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] word);
    logic        [31:0] lane;
    logic signed [31:0] sext_b;
    logic signed [31:0] sext_h;
    logic        [31:0] r;
    lane   = word >> {lo, 3'b000};
    sext_b = $signed(lane[7:0]);
    sext_h = $signed(lane[15:0]);
    case (f3)
      3'd0:    r = sext_b;
      3'd1:    r = sext_h;
      3'd4:    r = {24'd0, lane[7:0]};
      3'd5:    r = {16'd0, lane[15:0]};
      default: r = lane;
    endcase
    return r;
  endfunction

  assign req_ready = (state == IDLE);
  assign accept_p0 = req_valid & req_ready;
  assign legal_p0  = is_legal(req_store, req_funct3, req_addr[1:0]);

  // Stage p0 -> p1: request capture, bus drive and response generation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_valid  <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wstrb  <= 4'd0;
      mem_wdata  <= 32'd0;
      resp_valid <= 1'b0;
      resp_we    <= 1'b0;
      resp_rd    <= 5'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_we    <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_p0) begin
            if (legal_p0) begin
              state     <= MEM;
              mem_valid <= 1'b1;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wstrb <= req_store ? store_strobe(req_funct3[1:0], req_addr[1:0]) : 4'b0000;
              mem_wdata <= req_store ? store_data(req_funct3[1:0], req_wdata) : 32'd0;
            end else begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
              resp_rd    <= req_rd;
            end
          end
        end
        MEM: begin
          if (mem_ready) begin
            state      <= IDLE;
            mem_valid  <= 1'b0;
            resp_valid <= 1'b1;
            resp_we    <= ~store_p1;
            resp_rd    <= rd_p1;
            resp_rdata <= store_p1 ? 32'd0 : load_extend(funct3_p1, addr_lo_p1, mem_rdata);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request fields needed only at completion; no reset required
  always_ff @(posedge clk) begin
    if (accept_p0) begin
      store_p1   <= req_store;
      funct3_p1  <= req_funct3;
      addr_lo_p1 <= req_addr[1:0];
      rd_p1      <= req_rd;
    end
  end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Self-checking bench for rv32i_lsu: directed spec cases plus randomized traffic
// checked against a byte-addressed memory reference model.
module tb_rv32i_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic        resp_we;
  logic [4:0]  resp_rd;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int fails  = 0;

  logic [7:0] mem_b [0:255];

  typedef struct {
    logic        acc;
    int          resp_cnt;
    int          lat;
    logic        r_we;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [4:0]  r_rd;
    logic        got_mem;
    logic [31:0] m_addr;
    logic [3:0]  m_wstrb;
    logic [31:0] m_wdata;
    logic        unstable;
    logic        busy_ready;
  } op_t;

  rv32i_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_we(resp_we), .resp_rd(resp_rd),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // Issues one request at a negedge, acts as the memory, and records what the DUT did.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, input int waits,
                        input logic [31:0] rdat, output op_t o);
    int w;
    o.acc = 0; o.resp_cnt = 0; o.lat = 0; o.r_we = 0; o.r_err = 0; o.r_rdata = 0;
    o.r_rd = 0; o.got_mem = 0; o.m_addr = 0; o.m_wstrb = 0; o.m_wdata = 0;
    o.unstable = 0; o.busy_ready = 0;
    req_valid = 1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    o.acc = req_ready;
    @(posedge clk);
    #1 req_valid = 0; req_addr = $urandom; req_wdata = $urandom;
    w = 0;
    for (int c = 1; c <= waits + 5; c++) begin
      @(negedge clk);
      mem_ready = 0; mem_rdata = $urandom;
      if (resp_valid) begin
        o.resp_cnt++;
        if (o.resp_cnt == 1) begin
          o.lat = c; o.r_we = resp_we; o.r_err = resp_err; o.r_rdata = resp_rdata; o.r_rd = resp_rd;
        end
      end
      if (mem_valid) begin
        if (!o.got_mem) begin
          o.got_mem = 1; o.m_addr = mem_addr; o.m_wstrb = mem_wstrb; o.m_wdata = mem_wdata;
        end else if (mem_addr !== o.m_addr || mem_wstrb !== o.m_wstrb || mem_wdata !== o.m_wdata) begin
          o.unstable = 1;
        end
        if (req_ready) o.busy_ready = 1;
        if (w == waits) begin mem_ready = 1; mem_rdata = rdat; end
        w++;
      end
    end
    mem_ready = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++; if ({mem_valid, mem_addr, mem_wstrb, mem_wdata} !== '0) begin fails++;
      $display("FAIL reset_mem got=%b/%h/%b/%h exp=0", mem_valid, mem_addr, mem_wstrb, mem_wdata); end
    checks++; if ({resp_valid, resp_we, resp_rd, resp_rdata, resp_err} !== '0) begin fails++;
      $display("FAIL reset_resp got=%b/%b/%h/%h/%b exp=0", resp_valid, resp_we, resp_rd, resp_rdata, resp_err); end
    rst_n = 1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (mem_valid !== 1'b0 || resp_valid !== 1'b0) begin fails++;
      $display("FAIL reset_idle got=%b/%b exp=0/0", mem_valid, resp_valid); end
  endtask

  task automatic test_loads;
    op_t o;
    run_op(0, 3'd2, 32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF, o);
    checks++; if (o.m_addr !== 32'h100) begin fails++; $display("FAIL lw_addr got=%h exp=%h", o.m_addr, 32'h100); end
    checks++; if (o.m_wstrb !== 4'b0000) begin fails++; $display("FAIL lw_wstrb got=%b exp=0000", o.m_wstrb); end
    checks++; if (o.lat !== 2 || o.resp_cnt !== 1) begin fails++; $display("FAIL lw_lat got=%0d/%0d exp=2/1", o.lat, o.resp_cnt); end
    checks++; if (o.r_we !== 1'b1 || o.r_err !== 1'b0) begin fails++; $display("FAIL lw_we got=%b/%b exp=1/0", o.r_we, o.r_err); end
    checks++; if (o.r_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_rdata got=%h exp=DEADBEEF", o.r_rdata); end
    checks++; if (o.r_rd !== 5'd5) begin fails++; $display("FAIL lw_rd got=%0d exp=5", o.r_rd); end
    run_op(0, 3'd0, 32'h103, 32'h0, 5'd1, 0, 32'h80FF1234, o);
    checks++; if (o.r_rdata !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_rdata got=%h exp=FFFFFF80", o.r_rdata); end
    run_op(0, 3'd4, 32'h103, 32'h0, 5'd2, 0, 32'h80FF1234, o);
    checks++; if (o.r_rdata !== 32'h00000080) begin fails++; $display("FAIL lbu_rdata got=%h exp=00000080", o.r_rdata); end
    run_op(0, 3'd1, 32'h102, 32'h0, 5'd3, 0, 32'h80FF1234, o);
    checks++; if (o.r_rdata !== 32'hFFFF80FF) begin fails++; $display("FAIL lh_rdata got=%h exp=FFFF80FF", o.r_rdata); end
    run_op(0, 3'd5, 32'h102, 32'h0, 5'd4, 0, 32'h80FF1234, o);
    checks++; if (o.r_rdata !== 32'h000080FF) begin fails++; $display("FAIL lhu_rdata got=%h exp=000080FF", o.r_rdata); end
  endtask

  task automatic test_stores;
    op_t o;
    run_op(1, 3'd0, 32'h201, 32'h000000A5, 5'd6, 0, 32'h0, o);
    checks++; if (o.m_addr !== 32'h200) begin fails++; $display("FAIL sb_addr got=%h exp=00000200", o.m_addr); end
    checks++; if (o.m_wstrb !== 4'b0010) begin fails++; $display("FAIL sb_wstrb got=%b exp=0010", o.m_wstrb); end
    checks++; if (o.m_wdata !== 32'hA5A5A5A5) begin fails++; $display("FAIL sb_wdata got=%h exp=A5A5A5A5", o.m_wdata); end
    checks++; if (o.r_we !== 1'b0 || o.r_err !== 1'b0 || o.r_rdata !== 32'd0 || o.resp_cnt !== 1) begin fails++;
      $display("FAIL sb_resp got=%b/%b/%h/%0d exp=0/0/0/1", o.r_we, o.r_err, o.r_rdata, o.resp_cnt); end
    run_op(1, 3'd1, 32'h202, 32'h1234BEEF, 5'd6, 0, 32'h0, o);
    checks++; if (o.m_wstrb !== 4'b1100) begin fails++; $display("FAIL sh_wstrb got=%b exp=1100", o.m_wstrb); end
    checks++; if (o.m_wdata !== 32'hBEEFBEEF) begin fails++; $display("FAIL sh_wdata got=%h exp=BEEFBEEF", o.m_wdata); end
  endtask

  task automatic test_errors;
    op_t o;
    run_op(0, 3'd2, 32'h102, 32'h0, 5'd8, 0, 32'h0, o);
    checks++; if (o.got_mem !== 1'b0) begin fails++; $display("FAIL lw_mis_bus got=%b exp=0", o.got_mem); end
    checks++; if (o.lat !== 1 || o.r_err !== 1'b1 || o.r_we !== 1'b0 || o.r_rdata !== 32'd0) begin fails++;
      $display("FAIL lw_mis_resp got=%0d/%b/%b/%h exp=1/1/0/0", o.lat, o.r_err, o.r_we, o.r_rdata); end
    run_op(1, 3'd1, 32'h101, 32'hFFFF, 5'd8, 0, 32'h0, o);
    checks++; if (o.got_mem !== 1'b0 || o.r_err !== 1'b1 || o.lat !== 1) begin fails++;
      $display("FAIL sh_mis got=%b/%b/%0d exp=0/1/1", o.got_mem, o.r_err, o.lat); end
    run_op(0, 3'd3, 32'h100, 32'h0, 5'd8, 0, 32'h0, o);
    checks++; if (o.got_mem !== 1'b0 || o.r_err !== 1'b1 || o.r_we !== 1'b0) begin fails++;
      $display("FAIL f3_3_load got=%b/%b/%b exp=0/1/0", o.got_mem, o.r_err, o.r_we); end
    run_op(1, 3'd4, 32'h100, 32'h0, 5'd8, 0, 32'h0, o);
    checks++; if (o.got_mem !== 1'b0 || o.r_err !== 1'b1) begin fails++;
      $display("FAIL f3_4_store got=%b/%b exp=0/1", o.got_mem, o.r_err); end
  endtask

  task automatic test_wait_states;
    op_t o;
    run_op(1, 3'd2, 32'h3C4, 32'hCAFEF00D, 5'd0, 3, 32'h0, o);
    checks++; if (o.unstable !== 1'b0) begin fails++; $display("FAIL ws_stable got=%b exp=0", o.unstable); end
    checks++; if (o.busy_ready !== 1'b0) begin fails++; $display("FAIL ws_ready got=%b exp=0", o.busy_ready); end
    checks++; if (o.resp_cnt !== 1 || o.lat !== 5) begin fails++; $display("FAIL ws_resp got=%0d/%0d exp=1/5", o.resp_cnt, o.lat); end
    checks++; if (o.m_wdata !== 32'hCAFEF00D || o.m_wstrb !== 4'b1111) begin fails++;
      $display("FAIL ws_bus got=%h/%b exp=CAFEF00D/1111", o.m_wdata, o.m_wstrb); end
  endtask

  task automatic test_back_to_back;
    req_valid = 1; req_store = 0; req_funct3 = 3'd2; req_addr = 32'h102; req_rd = 5'd7;
    @(posedge clk); #1 req_store = 1; req_funct3 = 3'd1; req_addr = 32'h101;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || req_ready !== 1'b1) begin fails++;
      $display("FAIL b2b_err1 got=%b/%b/%b exp=1/1/1", resp_valid, resp_err, req_ready); end
    @(posedge clk); #1 req_store = 0; req_funct3 = 3'd2; req_addr = 32'h180; req_rd = 5'd9;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin fails++;
      $display("FAIL b2b_err2 got=%b/%b exp=1/1", resp_valid, resp_err); end
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    checks++; if (mem_valid !== 1'b1 || resp_valid !== 1'b0 || mem_addr !== 32'h180) begin fails++;
      $display("FAIL b2b_mem got=%b/%b/%h exp=1/0/00000180", mem_valid, resp_valid, mem_addr); end
    mem_ready = 1; mem_rdata = 32'h0BADF00D;
    @(posedge clk); #1 mem_ready = 0;
    req_valid = 1; req_store = 0; req_funct3 = 3'd0; req_addr = 32'h181; req_rd = 5'd3;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0BADF00D || resp_rd !== 5'd9 || req_ready !== 1'b1) begin fails++;
      $display("FAIL b2b_resp got=%b/%h/%0d/%b exp=1/0BADF00D/9/1", resp_valid, resp_rdata, resp_rd, req_ready); end
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    checks++; if (mem_valid !== 1'b1 || resp_valid !== 1'b0) begin fails++;
      $display("FAIL b2b_accept got=%b/%b exp=1/0", mem_valid, resp_valid); end
    mem_ready = 1; mem_rdata = 32'h00008000;
    @(negedge clk);
    mem_ready = 0;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFFFF80 || resp_rd !== 5'd3) begin fails++;
      $display("FAIL b2b_lb got=%b/%h/%0d exp=1/FFFFFF80/3", resp_valid, resp_rdata, resp_rd); end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    int seen;
    req_valid = 1; req_store = 0; req_funct3 = 3'd2; req_addr = 32'h40; req_rd = 5'd12;
    mem_ready = 0;
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    checks++; if (mem_valid !== 1'b1) begin fails++; $display("FAIL arst_pre got=%b exp=1", mem_valid); end
    #1 rst_n = 0;
    #1;
    checks++; if (mem_valid !== 1'b0 || req_ready !== 1'b1) begin fails++;
      $display("FAIL arst_drop got=%b/%b exp=0/1", mem_valid, req_ready); end
    @(negedge clk);
    rst_n = 1; mem_ready = 1; mem_rdata = 32'h12345678;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || mem_valid) seen++;
    end
    mem_ready = 0;
    checks++; if (seen !== 0) begin fails++; $display("FAIL arst_noresp got=%0d exp=0", seen); end
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL arst_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_random;
    op_t         o;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a, wd, rdat, exp_rdata, exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [4:0]  rd;
    logic [7:0]  base;
    int          size, waits;
    logic        legal;
    longint      v;
    for (int i = 0; i < 256; i++) mem_b[i] = 8'($urandom);
    for (int n = 0; n < 80; n++) begin
      st = 1'($urandom); f3 = 3'($urandom); a = $urandom; wd = $urandom; rd = 5'($urandom);
      waits = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) f3[2] = st ? 1'b0 : f3[2];
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
      if (size != 0 && $urandom_range(0, 2) != 0) a = a & ~(size - 1);
      legal = (size != 0) && ((a % size) == 0) && !(st && f3[2]) && !(f3[2] && size == 4);
      base = {a[7:2], 2'b00};
      rdat = {mem_b[base + 8'd3], mem_b[base + 8'd2], mem_b[base + 8'd1], mem_b[base]};
      v = 0;
      for (int k = 0; k < size; k++) v = v + (longint'(mem_b[a[7:0] + 8'(k)]) << (8 * k));
      if (!f3[2] && size > 0 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
        v = v - (longint'(1) << (8 * size));
      exp_rdata = (legal && !st) ? v[31:0] : 32'd0;
      exp_wstrb = 4'b0000;
      if (st) for (int k = 0; k < size; k++) exp_wstrb[a[1:0] + k] = 1'b1;
      exp_wdata = (size == 1) ? {4{wd[7:0]}} : (size == 2) ? {2{wd[15:0]}} : wd;
      run_op(st, f3, a, wd, rd, waits, rdat, o);
      checks++; if (o.resp_cnt !== 1 || o.lat !== (legal ? waits + 2 : 1)) begin fails++;
        $display("FAIL rnd_timing n=%0d got=%0d/%0d exp=1/%0d", n, o.resp_cnt, o.lat, legal ? waits + 2 : 1); end
      checks++; if (o.r_err !== !legal || o.r_we !== (legal && !st) || o.got_mem !== legal) begin fails++;
        $display("FAIL rnd_kind n=%0d got=%b/%b/%b exp=%b/%b/%b", n, o.r_err, o.r_we, o.got_mem, !legal, legal && !st, legal); end
      checks++; if (o.r_rdata !== exp_rdata) begin fails++;
        $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, o.r_rdata, exp_rdata); end
      if (legal) begin
        checks++; if (o.m_addr !== {a[31:2], 2'b00} || o.m_wstrb !== exp_wstrb) begin fails++;
          $display("FAIL rnd_bus n=%0d got=%h/%b exp=%h/%b", n, o.m_addr, o.m_wstrb, {a[31:2], 2'b00}, exp_wstrb); end
        checks++; if (o.unstable !== 1'b0 || o.busy_ready !== 1'b0) begin fails++;
          $display("FAIL rnd_hold n=%0d got=%b/%b exp=0/0", n, o.unstable, o.busy_ready); end
        if (st) begin
          checks++; if (o.m_wdata !== exp_wdata) begin fails++;
            $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, o.m_wdata, exp_wdata); end
          for (int k = 0; k < size; k++) mem_b[a[7:0] + 8'(k)] = wd[8 * k +: 8];
        end else begin
          checks++; if (o.r_rd !== rd) begin fails++; $display("FAIL rnd_rd n=%0d got=%0d exp=%0d", n, o.r_rd, rd); end
        end
      end
    end
  endtask

  initial begin
    clk = 0; rst_n = 0; req_valid = 0; req_store = 0; req_funct3 = 0; req_addr = 0;
    req_wdata = 0; req_rd = 0; mem_ready = 0; mem_rdata = 0;
    test_reset;
    test_loads;
    test_stores;
    test_errors;
    test_wait_states;
    test_back_to_back;
    test_async_reset;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/rv32i_lsu.md
# rv32i_lsu

Load/store unit for the RV32I core, sitting directly downstream of `rv32i_alu`: it takes the ALU's address result (rs1 + imm) and the store data, performs one aligned access on a simple valid/ready data-memory bus, and returns sign/zero-extended load data to writeback. Byte lanes, write strobes, misalignment detection and the request/memory/response handshakes are all handled here. Exactly one access is outstanding at a time.

## Interface
- No parameters; data and address width fixed at 32.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  EX stage presents a memory op.
- `req_ready`  out  1  LSU can accept a request.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr`  in  32  byte address (ALU result).
- `req_wdata`  in  32  rs2 value for stores.
- `req_rd`  in  5  destination register for loads.
- `mem_valid`  out  1  memory request pending.
- `mem_ready`  in  1  memory completes the request this cycle.
- `mem_addr`  out  32  word address, `{req_addr[31:2],2'b00}`.
- `mem_wstrb`  out  4  byte write enables; 0000 = read.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_rdata`  in  32  read word, valid when `mem_valid & mem_ready` on a read.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_we`  out  1  write `resp_rdata` to `resp_rd` (successful load only).
- `resp_rd`  out  5  destination register.
- `resp_rdata`  out  32  extended load data; 0 for stores/errors.
- `resp_err`  out  1  misaligned or illegal funct3 (access not performed).

## Operation
- FSM states: IDLE, MEM. `req_ready` = (state == IDLE), combinational.
- Accept when `req_valid & req_ready`; capture store flag, funct3, addr[1:0], wdata, rd.
- Legal: load funct3 ∈ {0,1,2,4,5}; store funct3 ∈ {0,1,2}. Alignment: halfword needs addr[0]=0, word needs addr[1:0]=0.
- Illegal/misaligned: stay in IDLE, no bus activity; next cycle `resp_valid=1, resp_err=1, resp_we=0, resp_rdata=0`.
- Legal: IDLE→MEM; `mem_valid=1` from the next cycle with addr/wstrb/wdata held stable until `mem_ready`. MEM→IDLE on `mem_ready`.
- Store strobes: SB `0001<<addr[1:0]`; SH `0011<<addr[1:0]`; SW `1111`. Data: SB `{4{wdata[7:0]}}`, SH `{2{wdata[15:0]}}`, SW `wdata`.
- Load: lane = `mem_rdata >> (8*addr[1:0])`; LB/LH sign-extend bit 7/15, LBU/LHU zero-extend, LW pass-through; result registered at the `mem_ready` edge.
- Store completion: `resp_valid=1, resp_we=0, resp_err=0, resp_rdata=0`.
- `mem_ready` while `mem_valid=0` is ignored.

## Timing
- Reset values: `mem_valid=0`, `mem_addr=0`, `mem_wstrb=0`, `mem_wdata=0`, `resp_valid=0`, `resp_we=0`, `resp_rd=0`, `resp_rdata=0`, `resp_err=0`; state IDLE (`req_ready=1`).
- Accept at edge N → `mem_valid` high in cycle N+1. `mem_ready` sampled high at edge M (M ≥ N+1) → `mem_valid` low and `resp_valid` pulse in cycle M+1; `req_ready` high in cycle M+1, so a new request can be accepted at edge M+1. Zero-wait memory: 2 cycles accept-to-response.
- Error path: accept at N → `resp_valid` in N+1; `req_ready` stays high, back-to-back requests allowed.
- `resp_valid` is never held beyond one cycle; there is no response backpressure.
- Async reset mid-access: `mem_valid` drops immediately; the pending access produces no response.

## Test plan
- LW addr 0x100, memory returns 0xDEADBEEF with `mem_ready` on first cycle → `mem_addr=0x100`, `mem_wstrb=0000`, 2 cycles later `resp_valid`, `resp_we=1`, `resp_rdata=0xDEADBEEF`.
- LB/LBU addr 0x103, rdata 0x80FF_1234 → 0xFFFFFF80 / 0x00000080; LH addr 0x102 → 0xFFFF80FF.
- SB addr 0x201, wdata 0x000000A5 → `mem_addr=0x200`, `mem_wstrb=0010`, `mem_wdata=0xA5A5A5A5`; SH addr 0x202 → `1100`, data duplicated halfword.
- LW addr 0x102 and SH addr 0x101 → no `mem_valid`, next cycle `resp_err=1`, `resp_we=0`, `resp_rdata=0`; funct3=3 load also errors.
- Wait states: `mem_ready` low 3 cycles → `mem_addr/wstrb/wdata` stable, `req_ready=0`, single `resp_valid` one cycle after `mem_ready`.
- Assert `rst_n=0` while `mem_valid=1` → `mem_valid` low asynchronously, no `resp_valid`, `req_ready=1` after release.
